// File: rtl/counter_pkg.sv
// Shared encodings for the prescaled up/down/bounce counter family.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/param_counter_board.sv
// Board wrapper: KEY[0] is an active-low push button, switches drive the
// controls and the counter state is shown on the red LEDs.
module param_counter_board #(
  parameter int unsigned PRESCALE = 32'd8388608
) (
  input  logic       CLOCK_50,
  input  logic [0:0] KEY,
  input  logic [7:0] SW,
  output logic [9:0] LEDR
);

  localparam int unsigned WIDTH = 32'd4;

  logic [1:0]       key_sync_q;
  logic [WIDTH-1:0] count_s;
  logic             tick_s, wrap_s, at_limit_s;

  // bring the asynchronous button into the clock domain before it resets anything
  always_ff @(posedge CLOCK_50) begin
    key_sync_q <= {key_sync_q[0], KEY[0]};
  end

  param_counter #(
    .WIDTH   (WIDTH),
    .PRESCALE(PRESCALE),
    .SATURATE(1'b0)
  ) u_counter (
    .clk     (CLOCK_50),
    .rst     (~key_sync_q[1]),
    .en      (SW[2]),
    .mode    (SW[1:0]),
    .load    (SW[3]),
    .load_val(SW[7:4]),
    .count   (count_s),
    .tick    (tick_s),
    .wrap    (wrap_s),
    .at_limit(at_limit_s)
  );

  assign LEDR = {3'b000, at_limit_s, wrap_s, tick_s, count_s};

endmodule

// File: rtl/tick_gen.sv
// Free-running prescaler: counts 0..PRESCALE-1 and emits a registered one-cycle
// tick in the cycle after the terminal count. clr restarts it like a reset.
module tick_gen #(
  parameter int unsigned PRESCALE = 32'd8388608
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (PRESCALE > 32'd1) ? $clog2(PRESCALE) : 32'd1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 32'd1);
  localparam logic [CW-1:0] ONE  = CW'(32'd1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // next prescaler count and tick
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clr) begin
      cnt_d  = '0;
      tick_d = 1'b0;
    end else begin
      tick_d = (cnt_q == LAST);
      if (cnt_q == LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
  end

  // prescaler state register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/param_counter.sv
// Prescaled counter with up, down, ping-pong and hold modes, synchronous load,
// optional saturation and a one-cycle boundary pulse.
module param_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 32'd4,
  parameter int unsigned PRESCALE = 32'd8388608,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             wrap,
  output logic             at_limit
);

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(32'd1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  dir_e             dir_q, dir_d;
  logic [WIDTH-1:0] inc_s, dec_s;
  mode_e            mode_s;
  logic             tick_s;

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .clr (load),
    .tick(tick_s)
  );

  assign mode_s = mode_e'(mode);
  assign inc_s  = count_q + ONE;
  assign dec_s  = count_q - ONE;

  // next count, direction and boundary pulse; load overrides any pending tick
  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = load_val;
    end else if (tick_s && en) begin
      case (mode_s)
        MODE_UP: begin
          if (count_q != MAX) begin
            count_d = inc_s;
          end else if (SATURATE) begin
            count_d = MAX;
          end else begin
            count_d = '0;
            wrap_d  = 1'b1;
          end
        end
        MODE_DOWN: begin
          if (count_q != '0) begin
            count_d = dec_s;
          end else if (SATURATE) begin
            count_d = '0;
          end else begin
            count_d = MAX;
            wrap_d  = 1'b1;
          end
        end
        MODE_BOUNCE: begin
          // a count already sitting on the far limit turns around immediately
          if (dir_q == DIR_UP) begin
            if (count_q == MAX) begin
              count_d = dec_s;
              dir_d   = DIR_DOWN;
              wrap_d  = 1'b1;
            end else begin
              count_d = inc_s;
              if (inc_s == MAX) begin
                dir_d  = DIR_DOWN;
                wrap_d = 1'b1;
              end else begin
                dir_d  = DIR_UP;
              end
            end
          end else begin
            if (count_q == '0) begin
              count_d = inc_s;
              dir_d   = DIR_UP;
              wrap_d  = 1'b1;
            end else begin
              count_d = dec_s;
              if (dec_s == '0) begin
                dir_d  = DIR_UP;
                wrap_d = 1'b1;
              end else begin
                dir_d  = DIR_DOWN;
              end
            end
          end
        end
        MODE_HOLD: begin
          count_d = count_q;
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end else begin
      count_d = count_q;
    end
  end

  // counter state register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      dir_q   <= DIR_UP;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
    end
  end

  // limit flag follows the bound the current mode and direction are heading to
  always_comb begin
    at_limit = 1'b0;
    case (mode_s)
      MODE_UP:     at_limit = (count_q == MAX);
      MODE_DOWN:   at_limit = (count_q == '0);
      MODE_BOUNCE: at_limit = (count_q == MAX) || (count_q == '0);
      MODE_HOLD:   at_limit = (dir_q == DIR_UP) ? (count_q == MAX) : (count_q == '0);
      default:     at_limit = 1'b0;
    endcase
  end

  assign count = count_q;
  assign tick  = tick_s;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_param_counter.sv
// Directed bench for param_counter across several parameter sets plus the board wrapper.
module tb_param_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] lv4 = 4'd0;
  logic [2:0] lv3 = 3'd0;
  logic       lv1 = 1'b0;
  logic [0:0] key = 1'b0;
  logic [7:0] sw = 8'd0;
  logic [9:0] ledr;

  logic [3:0] cnt_a, cnt_b, cnt_d;
  logic [2:0] cnt_c;
  logic       cnt_e;
  logic tick_a, wrap_a, lim_a, tick_b, wrap_b, lim_b, tick_c, wrap_c, lim_c;
  logic tick_d, wrap_d, lim_d, tick_e, wrap_e, lim_e;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_counter #(.WIDTH(4), .PRESCALE(1), .SATURATE(1'b0)) u_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(lv4),
    .count(cnt_a), .tick(tick_a), .wrap(wrap_a), .at_limit(lim_a));
  param_counter #(.WIDTH(4), .PRESCALE(3), .SATURATE(1'b0)) u_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(lv4),
    .count(cnt_b), .tick(tick_b), .wrap(wrap_b), .at_limit(lim_b));
  param_counter #(.WIDTH(3), .PRESCALE(1), .SATURATE(1'b0)) u_c (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(lv3),
    .count(cnt_c), .tick(tick_c), .wrap(wrap_c), .at_limit(lim_c));
  param_counter #(.WIDTH(4), .PRESCALE(1), .SATURATE(1'b1)) u_d (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(lv4),
    .count(cnt_d), .tick(tick_d), .wrap(wrap_d), .at_limit(lim_d));
  param_counter #(.WIDTH(1), .PRESCALE(1), .SATURATE(1'b0)) u_e (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(lv1),
    .count(cnt_e), .tick(tick_e), .wrap(wrap_e), .at_limit(lim_e));
  param_counter_board #(.PRESCALE(2)) u_board (
    .CLOCK_50(clk), .KEY(key), .SW(sw), .LEDR(ledr));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] m);
    mode = m; en = 1'b1; load = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(2'b00);
    checks++; if (cnt_a !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", cnt_a); end
    checks++; if (tick_a !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", tick_a); end
    checks++; if (wrap_a !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b exp 0", wrap_a); end
    checks++; if (lim_a !== 1'b0) begin errors++; $display("FAIL reset_at_limit got %b exp 0", lim_a); end
  endtask

  task automatic test_up();
    logic [3:0] e;
    do_reset(2'b00);
    step();
    checks++; if (tick_a !== 1'b1 || cnt_a !== 4'd0) begin errors++; $display("FAIL up_first_tick tick %b count %0d exp 1/0", tick_a, cnt_a); end
    for (int i = 1; i <= 16; i++) begin
      step();
      e = 4'(i);
      checks++; if (cnt_a !== e) begin errors++; $display("FAIL up_count[%0d] got %0d exp %0d", i, cnt_a, e); end
      checks++; if (wrap_a !== (i == 16)) begin errors++; $display("FAIL up_wrap[%0d] got %b exp %b", i, wrap_a, (i == 16)); end
      checks++; if (lim_a !== (e == 4'd15)) begin errors++; $display("FAIL up_at_limit[%0d] got %b exp %b", i, lim_a, (e == 4'd15)); end
    end
  endtask

  task automatic test_enable_hold();
    do_reset(2'b00);
    step(); step(); step();
    checks++; if (cnt_a !== 4'd2) begin errors++; $display("FAIL en_pre got %0d exp 2", cnt_a); end
    en = 1'b0;
    step(); step();
    checks++; if (cnt_a !== 4'd2 || tick_a !== 1'b1) begin errors++; $display("FAIL en_gate count %0d tick %b exp 2/1", cnt_a, tick_a); end
    en = 1'b1; mode = 2'b11;
    step(); step();
    checks++; if (cnt_a !== 4'd2 || wrap_a !== 1'b0) begin errors++; $display("FAIL hold count %0d wrap %b exp 2/0", cnt_a, wrap_a); end
    mode = 2'b00;
    step();
    checks++; if (cnt_a !== 4'd3) begin errors++; $display("FAIL hold_resume got %0d exp 3", cnt_a); end
  endtask

  task automatic test_down();
    do_reset(2'b01);
    step(); step();
    checks++; if (tick_b !== 1'b0) begin errors++; $display("FAIL down_no_early_tick got %b exp 0", tick_b); end
    step();
    checks++; if (tick_b !== 1'b1 || cnt_b !== 4'd0) begin errors++; $display("FAIL down_tick3 tick %b count %0d exp 1/0", tick_b, cnt_b); end
    step();
    checks++; if (cnt_b !== 4'd15 || wrap_b !== 1'b1 || tick_b !== 1'b0) begin errors++; $display("FAIL down_wrap count %0d wrap %b tick %b exp 15/1/0", cnt_b, wrap_b, tick_b); end
    step(); step();
    checks++; if (tick_b !== 1'b1 || cnt_b !== 4'd15 || wrap_b !== 1'b0) begin errors++; $display("FAIL down_second_tick tick %b count %0d wrap %b exp 1/15/0", tick_b, cnt_b, wrap_b); end
    step();
    checks++; if (cnt_b !== 4'd14 || wrap_b !== 1'b0 || lim_b !== 1'b0) begin errors++; $display("FAIL down_14 count %0d wrap %b lim %b exp 14/0/0", cnt_b, wrap_b, lim_b); end
  endtask

  task automatic test_bounce();
    int seq [15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    logic [2:0] e;
    do_reset(2'b10);
    step();
    checks++; if (tick_c !== 1'b1 || cnt_c !== 3'd0 || lim_c !== 1'b1) begin errors++; $display("FAIL bounce_start tick %b count %0d lim %b exp 1/0/1", tick_c, cnt_c, lim_c); end
    for (int i = 0; i < 15; i++) begin
      step();
      e = 3'(seq[i]);
      checks++; if (cnt_c !== e) begin errors++; $display("FAIL bounce_count[%0d] got %0d exp %0d", i, cnt_c, e); end
      checks++; if (wrap_c !== ((i == 6) || (i == 13))) begin errors++; $display("FAIL bounce_wrap[%0d] got %b", i, wrap_c); end
      checks++; if (lim_c !== ((e == 3'd7) || (e == 3'd0))) begin errors++; $display("FAIL bounce_at_limit[%0d] got %b", i, lim_c); end
    end
    for (int i = 0; i < 6; i++) step();
    mode = 2'b11;
    step();
    checks++; if (cnt_c !== 3'd7 || lim_c !== 1'b0) begin errors++; $display("FAIL bounce_hold_dir count %0d lim %b exp 7/0", cnt_c, lim_c); end
    mode = 2'b10;
    step();
    checks++; if (cnt_c !== 3'd6) begin errors++; $display("FAIL bounce_dir_persist got %0d exp 6", cnt_c); end
    rst = 1'b1; mode = 2'b11;
    step();
    rst = 1'b0;
    checks++; if (cnt_c !== 3'd0 || wrap_c !== 1'b0 || lim_c !== 1'b0) begin errors++; $display("FAIL bounce_reset_dir count %0d wrap %b lim %b exp 0/0/0", cnt_c, wrap_c, lim_c); end
  endtask

  task automatic test_saturate();
    do_reset(2'b00);
    load = 1'b1; lv4 = 4'd14;
    step();
    load = 1'b0;
    checks++; if (cnt_d !== 4'd14 || tick_d !== 1'b0) begin errors++; $display("FAIL sat_load count %0d tick %b exp 14/0", cnt_d, tick_d); end
    step();
    checks++; if (cnt_d !== 4'd14) begin errors++; $display("FAIL sat_first got %0d exp 14", cnt_d); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (cnt_d !== 4'd15 || wrap_d !== 1'b0 || lim_d !== 1'b1) begin errors++; $display("FAIL sat_hold[%0d] count %0d wrap %b lim %b exp 15/0/1", i, cnt_d, wrap_d, lim_d); end
    end
  endtask

  task automatic test_load_tick();
    do_reset(2'b00);
    step(); step(); step();
    checks++; if (tick_b !== 1'b1) begin errors++; $display("FAIL load_pre_tick got %b exp 1", tick_b); end
    load = 1'b1; lv4 = 4'd5;
    step();
    load = 1'b0;
    checks++; if (cnt_b !== 4'd5 || tick_b !== 1'b0 || wrap_b !== 1'b0) begin errors++; $display("FAIL load_priority count %0d tick %b wrap %b exp 5/0/0", cnt_b, tick_b, wrap_b); end
    step(); step();
    checks++; if (cnt_b !== 4'd5 || tick_b !== 1'b0) begin errors++; $display("FAIL load_wait count %0d tick %b exp 5/0", cnt_b, tick_b); end
    step();
    checks++; if (tick_b !== 1'b1) begin errors++; $display("FAIL load_next_tick got %b exp 1", tick_b); end
    step();
    checks++; if (cnt_b !== 4'd6) begin errors++; $display("FAIL load_resume got %0d exp 6", cnt_b); end
  endtask

  task automatic test_rst_mid();
    do_reset(2'b00);
    load = 1'b1; lv4 = 4'd9;
    step();
    load = 1'b0;
    step(); step(); step();
    checks++; if (cnt_b !== 4'd9 || tick_b !== 1'b1) begin errors++; $display("FAIL rst_mid_pre count %0d tick %b exp 9/1", cnt_b, tick_b); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (cnt_b !== 4'd0 || wrap_b !== 1'b0 || tick_b !== 1'b0) begin errors++; $display("FAIL rst_mid count %0d wrap %b tick %b exp 0/0/0", cnt_b, wrap_b, tick_b); end
    step(); step();
    checks++; if (tick_b !== 1'b0 || cnt_b !== 4'd0) begin errors++; $display("FAIL rst_mid_wait tick %b count %0d exp 0/0", tick_b, cnt_b); end
    step();
    checks++; if (tick_b !== 1'b1) begin errors++; $display("FAIL rst_mid_tick got %b exp 1", tick_b); end
    step();
    checks++; if (cnt_b !== 4'd1) begin errors++; $display("FAIL rst_mid_resume got %0d exp 1", cnt_b); end
  endtask

  task automatic test_width1();
    logic [2:0] wr_tab [3] = '{3'b010, 3'b101, 3'b111};
    for (int m = 0; m < 3; m++) begin
      do_reset(2'(m));
      step();
      checks++; if (tick_e !== 1'b1 || cnt_e !== 1'b0) begin errors++; $display("FAIL w1_start[%0d] tick %b count %b exp 1/0", m, tick_e, cnt_e); end
      if (m == 0) begin
        checks++; if (lim_e !== 1'b0) begin errors++; $display("FAIL w1_at_limit got %b exp 0", lim_e); end
      end
      for (int k = 0; k < 3; k++) begin
        step();
        checks++; if (cnt_e !== ((k % 2) == 0)) begin errors++; $display("FAIL w1_count[%0d][%0d] got %b", m, k, cnt_e); end
        checks++; if (wrap_e !== wr_tab[m][k]) begin errors++; $display("FAIL w1_wrap[%0d][%0d] got %b exp %b", m, k, wrap_e, wr_tab[m][k]); end
      end
    end
  endtask

  task automatic test_board();
    key = 1'b0; sw = 8'b0000_0100;
    for (int i = 0; i < 4; i++) step();
    checks++; if (ledr !== 10'd0) begin errors++; $display("FAIL board_reset got %b exp 0", ledr); end
    key = 1'b1;
    for (int i = 0; i < 7; i++) step();
    checks++; if (ledr !== 10'b00_0000_0010) begin errors++; $display("FAIL board_count got %b exp 0000000010", ledr); end
  endtask

  initial begin
    test_reset();
    test_up();
    test_enable_hold();
    test_down();
    test_bounce();
    test_saturate();
    test_load_tick();
    test_rst_mid();
    test_width1();
    test_board();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
